// File: rtl/shift_seq_ctrl.sv
// Sequencer for the one-hot shift datapath: one load strobe, CYCLES shift strobes, one done pulse.
// Optional HOLD state and pause input are built when SHIFT_SEQ_PAUSE_EN is defined.
module shift_seq_ctrl #(
  parameter  int WIDTH  = 8,
  parameter  int CYCLES = 18,
  localparam int POS_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic             load,
  output logic             shift_left,
  output logic             shift_right,
  output logic             dir,
  output logic [POS_W-1:0] pos,
  output logic [4:0]       step_cnt,
  output logic             busy,
  output logic             run_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    HOLD   = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [POS_W-1:0] POS_MAX   = POS_W'(WIDTH - 1);
  localparam logic [4:0]       LAST_STEP = 5'(CYCLES);

  state_t           state;
  logic [1:0]       mode_q;
  logic [POS_W-1:0] pos_nxt;
  logic [4:0]       step_nxt;
  logic             at_end;
  logic             bounce;

`ifndef SHIFT_SEQ_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause;
`endif

  assign bounce   = (mode_q == 2'b10);
  assign step_nxt = step_cnt + 5'd1;

  // Explicit wrap keeps the position correct for non-power-of-two widths.
  always_comb begin
    pos_nxt = pos;
    if (!dir) pos_nxt = (pos == POS_MAX) ? '0 : pos + 1'b1;
    else      pos_nxt = (pos == '0) ? POS_MAX : pos - 1'b1;
  end

  assign at_end = (!dir && pos_nxt == POS_MAX) || (dir && pos_nxt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mode_q   <= 2'b00;
      dir      <= 1'b0;
      pos      <= '0;
      step_cnt <= 5'd0;
    end else if (abort && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            state  <= LOAD;
          end
        end
        LOAD: begin
          step_cnt <= 5'd0;
          pos      <= '0;
          dir      <= (mode_q == 2'b01);
          state    <= RUN;
        end
        RUN: begin
          step_cnt <= step_nxt;
          pos      <= pos_nxt;
          if (bounce && at_end) dir <= ~dir;
          // The final step always finishes, so a late pause cannot add an extra strobe.
          if (step_nxt == LAST_STEP) state <= FINISH;
`ifdef SHIFT_SEQ_PAUSE_EN
          else if (pause)            state <= HOLD;
`endif
        end
`ifdef SHIFT_SEQ_PAUSE_EN
        HOLD: begin
          if (!pause) state <= RUN;
        end
`endif
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign load        = (state == LOAD);
  assign shift_left  = (state == RUN) && !dir;
  assign shift_right = (state == RUN) && dir;
  assign run_done    = (state == FINISH);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with hand-computed expectations (WIDTH=8, CYCLES=18).
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, abort, pause;
  logic [1:0] mode;
  logic       load, shift_left, shift_right, dir, busy, run_done;
  logic [2:0] pos;
  logic [4:0] step_cnt;

  int tests = 0;
  int fails = 0;
  int t, strobes, holds, other;

  logic [17:0] bounce_dir;
  int          bounce_pos [18];

  shift_seq_ctrl #(.WIDTH(8), .CYCLES(18)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode), .pause(pause),
    .load(load), .shift_left(shift_left), .shift_right(shift_right), .dir(dir),
    .pos(pos), .step_cnt(step_cnt), .busy(busy), .run_done(run_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bounce_dir = 18'h03F80;
    bounce_pos = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3};
    reset = 1'b1; start = 1'b1; abort = 1'b0; pause = 1'b0; mode = 2'b00;

    // Reset held with start high
    tick(); tick();
    check("rst_outs", {load, shift_left, shift_right, dir, busy, run_done}, 6'b0);
    check("rst_pos", 32'(pos), 0);
    check("rst_step", 32'(step_cnt), 0);
    reset = 1'b0; start = 1'b0;
    tick();
    check("post_rst_idle", {busy, load}, 2'b00);

    // Left-only run, with ignored starts in RUN and FINISH
    mode = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    check("left_load", {load, shift_left, shift_right, busy}, 4'b1001);
    tick();
    for (int i = 0; i < 18; i++) begin
      check("left_strobe", {load, shift_left, shift_right, run_done}, 4'b0100);
      check("left_step", 32'(step_cnt), 32'(i));
      check("left_pos", 32'(pos), 32'(i % 8));
      start = (i == 3); mode = (i == 3) ? 2'b01 : 2'b00;
      tick();
      start = 1'b0;
    end
    check("left_done", {run_done, busy, shift_left}, 3'b110);
    check("left_final_pos", 32'(pos), 2);
    check("left_final_step", 32'(step_cnt), 18);
    start = 1'b1; mode = 2'b01;
    tick();
    start = 1'b0; mode = 2'b00;
    check("finish_start_ignored", {busy, load, run_done}, 3'b000);
    tick();
    check("still_idle", {busy, load}, 2'b00);

    // Bounce run
    mode = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    check("bounce_load", 32'(load), 1);
    tick();
    for (int i = 0; i < 18; i++) begin
      check("bounce_dir", {shift_left, shift_right, dir}, {!bounce_dir[i], bounce_dir[i], bounce_dir[i]});
      check("bounce_pos", 32'(pos), 32'(bounce_pos[i]));
      tick();
    end
    check("bounce_done", 32'(run_done), 1);
    check("bounce_final_pos", 32'(pos), 4);
    check("bounce_final_dir", 32'(dir), 0);
    tick();

    // Right-only run started from IDLE
    mode = 2'b01; start = 1'b1;
    tick();
    start = 1'b0; mode = 2'b00;
    tick();
    strobes = 0; other = 0;
    for (int i = 0; i < 18; i++) begin
      strobes += int'(shift_right);
      other   += int'(shift_left) + int'(load) + int'(run_done);
      tick();
    end
    check("right_strobes", 32'(strobes), 18);
    check("right_other", 32'(other), 0);
    check("right_done", 32'(run_done), 1);
    check("right_final_pos", 32'(pos), 6);
    tick();

    // Pause three cycles at step 6 (ignored when the feature is not built)
    mode = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    t = 1; strobes = 0; holds = 0;
    while (!run_done && t < 60) begin
      strobes += int'(shift_left);
      if (busy && !load && !shift_left && !shift_right) begin
        holds++;
        check("hold_step_frozen", 32'(step_cnt), 6);
      end
      pause = (t >= 7 && t <= 9);
      tick();
      t++;
    end
    pause = 1'b0;
    check("pause_strobes", 32'(strobes), 18);
`ifdef SHIFT_SEQ_PAUSE_EN
    check("pause_holds", 32'(holds), 3);
    check("pause_done_cycle", 32'(t), 23);
`else
    check("pause_holds", 32'(holds), 0);
    check("pause_done_cycle", 32'(t), 20);
`endif
    tick();

    // Abort at step_cnt = 5
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("abort_at_step", 32'(step_cnt), 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {busy, shift_left, shift_right, run_done}, 4'b0000);
    other = 0;
    for (int i = 0; i < 25; i++) begin
      other += int'(shift_left) + int'(shift_right) + int'(run_done) + int'(load) + int'(busy);
      tick();
    end
    check("abort_quiet", 32'(other), 0);

    // Reset mid-run
    mode = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_outs", {load, shift_left, shift_right, dir, busy, run_done}, 6'b0);
    check("midrst_cnt", {29'(pos), 29'(step_cnt)}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencing controller for the one-hot shift datapath. It accepts a start request with a run mode, issues one `load` strobe, then exactly `CYCLES` single-cycle `shift_left`/`shift_right` strobes (left-only, right-only or bounce), and signals completion with a one-cycle `run_done` pulse. It sits between top-level control (buttons/host FSM) and the datapath. It tracks the lit-bit position itself, so it never needs to read the datapath's `count` bus.

## Interface
- `WIDTH`, 8: datapath register width; bounce end points are bit 0 and bit `WIDTH-1`.
- `CYCLES`, 18: shift strobes per run, legal range 1..31.
- `POS_W` (localparam), `$clog2(WIDTH)`: position counter width.
- `clk` in 1: the single clock; every register updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: run request, sampled in IDLE only.
- `abort` in 1: cancels any run.
- `mode` in 2: run mode, latched on accepted start. 00 = left-only, 01 = right-only, 10 = bounce, 11 = treated as 00.
- `pause` in 1: freezes the run (feature-gated, see Configuration).
- `load` out 1: datapath load strobe.
- `shift_left` out 1: datapath left-shift strobe.
- `shift_right` out 1: datapath right-shift strobe.
- `dir` out 1: current direction, 0 = left, 1 = right.
- `pos` out `POS_W`: tracked index of the lit bit.
- `step_cnt` out 5: shifts issued in the current run.
- `busy` out 1: high in any state other than IDLE.
- `run_done` out 1: one-cycle completion pulse.

## Operation
- **States:** IDLE, LOAD, RUN, HOLD, FINISH.
- **Outputs:** all outputs are Moore-decoded from registered state, `dir`, `pos` and `step_cnt`.
  - `load` = (state == LOAD).
  - `shift_left` = (RUN && !dir); `shift_right` = (RUN && dir).
  - `run_done` = (state == FINISH).
- **Reset:** state goes to IDLE and all outputs are 0, including `dir`, `pos` and `step_cnt`.
- **Priority, highest first:** `reset`, then `abort`, then `pause`, then normal flow.
- **IDLE:** `start` = 1 goes to LOAD and latches `mode`. Otherwise stay in IDLE.
- **LOAD:** clear `step_cnt` and `pos` to 0. Set `dir` to 1 for mode 01, else 0. Go to RUN.
- **RUN, one shift per cycle:**
  - `step_cnt` increments by 1.
  - `pos` increments by 1 on a left step and decrements by 1 on a right step, modulo `WIDTH`.
  - If the incremented `step_cnt` equals `CYCLES`, go to FINISH.
- **Bounce mode:** `dir` toggles on the edge where the new `pos` equals `WIDTH-1` while moving left, or 0 while moving right. The step that reaches the end bit is therefore the last step in that direction.
- **Left-only and right-only modes:** `dir` is constant and `pos` wraps modulo `WIDTH`.
- **FINISH:** assert `run_done` for one cycle, then go to IDLE.
- **Pause:** `pause` = 1 in RUN moves to HOLD at the next edge. While in HOLD, no strobes are issued and counters are frozen. `pause` = 0 returns to RUN.
- **Abort:** `abort` = 1 in LOAD, RUN, HOLD or FINISH returns to IDLE at the next edge. No `run_done` is issued. `step_cnt`, `pos` and `dir` keep their last values until the next LOAD.
- **Start while not IDLE:** ignored, not queued. This includes the FINISH cycle.
- **Strobe count:** at most `CYCLES` shift strobes per run; `load` and shift strobes are never high in the same cycle.

## Timing
Let `start` be sampled at edge k.
- `load` is high in cycle k+1.
- Shift strobes are high in cycles k+2 through k+1+`CYCLES` when there is no pause.
- `run_done` is high in cycle k+2+`CYCLES`.
- `busy` is high from cycle k+1 through k+2+`CYCLES`.
- The earliest next `start` is accepted at edge k+3+`CYCLES`.
- Each cycle spent in HOLD adds exactly one cycle to all later events.
- `pause` and `abort` take effect with one-cycle latency.
- A `reset` asserted mid-run reaches IDLE at the next edge with all outputs 0.

## Configuration
- **Macro:** `SHIFT_SEQ_PAUSE_EN`.
- **Defined:** HOLD state and `pause` behave as described above.
- **Undefined:** HOLD is not built and `pause` is ignored; the port stays present and unused. A run always takes `CYCLES`+2 cycles from the LOAD cycle through the FINISH cycle, unless it is aborted.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `start` = 1 → all outputs 0, state IDLE, no `load`.
- **Left-only run:** `mode` = 00, pulse `start` → `load` for 1 cycle, then 18 consecutive `shift_left` cycles, then `run_done` 20 cycles after the start edge. Final `pos` = 2, `step_cnt` = 18.
- **Bounce run:** `mode` = 10 → strobe sequence is 7 left, 7 right, 4 left. `dir` toggles after steps 7 and 14; final `pos` = 4.
- **Pause (macro defined):** raise `pause` for 3 cycles at step 6 → HOLD for 3 cycles with `step_cnt` frozen at 6. Total strobes = 18; `run_done` arrives 3 cycles later than in the left-only run.
- **Abort:** assert `abort` for 1 cycle at `step_cnt` = 5 → IDLE at the next edge, no further strobes, no `run_done`, `busy` = 0.
- **Start while busy:** pulse `start` with `mode` = 01 in RUN and again in FINISH → both ignored and the original mode is unaffected. A new `start` in IDLE then produces 18 `shift_right` strobes.
